// File: rtl/priority_arbiter_fsm_pkg.sv
// Shared constants for the 8-requester priority arbiter: FSM encoding,
// requester count, code width and the reset value of the round-robin pointer.
package priority_arbiter_fsm_pkg;

    localparam int N_REQ_C = 8;
    localparam int CODE_W  = 3;

    // Pointer starts at the top index so the first round-robin search
    // begins at index 0, matching the fixed-priority pick.
    localparam logic [CODE_W-1:0] LAST_CODE_RST = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/priority_arbiter_fsm_pick.sv
// rotating_priority_pick: combinational lowest-index-first selection of one
// request bit, optionally searching upward from a rotating start index.
module rotating_priority_pick
    import priority_arbiter_fsm_pkg::*;
(
    input  logic [N_REQ_C-1:0] req,
    input  logic [CODE_W-1:0]  start,
    input  logic               rr_en,
    output logic [CODE_W-1:0]  code,
    output logic               any
);

    logic [2*N_REQ_C-1:0] doubled;
    logic [N_REQ_C-1:0]   rotated;
    logic [CODE_W-1:0]    local_code;

    // Rotate right by start so the search origin lands on bit 0.
    always_comb begin
        doubled = {req, req} >> start;
        rotated = rr_en ? doubled[N_REQ_C-1:0] : req;
    end

    // Lowest set index wins; scanning downward lets the last hit stick.
    always_comb begin
        local_code = '0;
        for (int i = N_REQ_C - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                local_code = CODE_W'(i);
            end
        end
    end

    // Undo the rotation; the 3-bit add wraps modulo 8.
    always_comb begin
        code = rr_en ? CODE_W'(local_code + start) : local_code;
        any  = |req;
    end

endmodule

// File: rtl/priority_arbiter_fsm.sv
// priority_arbiter_fsm: shares one resource among eight clients with grant
// holding, owner release, a hold timeout and optional round-robin rotation.
//
// Handshake: a client raises req[i] and holds it until grant[i] is seen;
// it keeps req[i] high for as long as it wants the resource and releases by
// pulsing done or dropping req[i]. A release is honoured at the next edge and
// is always followed by exactly one idle cycle with grant == 0.
module priority_arbiter_fsm
    import priority_arbiter_fsm_pkg::*;
#(
    parameter int N_REQ    = N_REQ_C,
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic               done,
    input  logic               mode,
    output logic [N_REQ-1:0]   grant,
    output logic [CODE_W-1:0]  grant_code,
    output logic               grant_valid,
    output logic               timeout,
    output state_t             fsm_state
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic [CODE_W-1:0] last_code;
    logic [CODE_W-1:0] pick_code;
    logic              pick_any;
    logic              owner_drop;
    logic              hold_expired;
    logic              release_now;

    rotating_priority_pick u_pick (
        .req   (req),
        .start (CODE_W'(last_code + 3'd1)),
        .rr_en (mode),
        .code  (pick_code),
        .any   (pick_any)
    );

    // Release causes evaluated against the registered owner.
    always_comb begin
        owner_drop   = ~req[grant_code];
        hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
        release_now  = done | owner_drop | hold_expired;
    end

    // Arbitration FSM with registered outputs, hold counter and RR pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_state   <= IDLE;
            grant       <= '0;
            grant_code  <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            hold_cnt    <= '0;
            last_code   <= LAST_CODE_RST;
        end else begin
            timeout <= 1'b0;
            case (fsm_state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (pick_any) begin
                        grant       <= N_REQ'(1) << pick_code;
                        grant_code  <= pick_code;
                        grant_valid <= 1'b1;
                        last_code   <= pick_code;
                        fsm_state   <= BUSY;
                    end else begin
                        grant       <= '0;
                        grant_code  <= '0;
                        grant_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        grant       <= '0;
                        grant_code  <= '0;
                        grant_valid <= 1'b0;
                        hold_cnt    <= '0;
                        // Only a pure timeout is flagged; done or owner drop win.
                        timeout     <= hold_expired & ~done & ~owner_drop;
                        fsm_state   <= IDLE;
                    end else begin
                        hold_cnt    <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    fsm_state <= IDLE;
                end
            endcase
        end
    end

endmodule
